// File: rtl/sr_flipflop_bank.sv
// Bank of WIDTH independent clocked SR flip-flops with selectable S=R=1 policy,
// registered rise/fall pulses, and a saturating conflict counter.
module sr_flipflop_bank #(
  parameter int unsigned            WIDTH         = 8,
  parameter int                     CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0]       RESET_VALUE   = '0,
  parameter int unsigned            CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    POL_HOLD,
    POL_SET,
    POL_RESET,
    POL_TOGGLE
  } policy_e;

  // Unrecognised mode values fall back to hold.
  localparam policy_e POLICY = (CONFLICT_MODE == 1) ? POL_SET    :
                               (CONFLICT_MODE == 2) ? POL_RESET  :
                               (CONFLICT_MODE == 3) ? POL_TOGGLE : POL_HOLD;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_conflict;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic             w_conflict;

  always_comb begin
    w_q_next = r_q;
    if (clr) begin
      w_q_next = RESET_VALUE;
    end else if (en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        unique case ({s[i], r[i]})
          2'b10:   w_q_next[i] = 1'b1;
          2'b01:   w_q_next[i] = 1'b0;
          2'b11: begin
            unique case (POLICY)
              POL_SET:    w_q_next[i] = 1'b1;
              POL_RESET:  w_q_next[i] = 1'b0;
              POL_TOGGLE: w_q_next[i] = ~r_q[i];
              default:    w_q_next[i] = r_q[i];
            endcase
          end
          default: w_q_next[i] = r_q[i];
        endcase
      end
    end
  end

  // Conflict is flagged regardless of the policy that resolves it.
  assign w_conflict = en & ~clr & (|(s & r));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q        <= RESET_VALUE;
      r_rise     <= '0;
      r_fall     <= '0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_q        <= w_q_next;
      r_rise     <= ~r_q & w_q_next;
      r_fall     <= r_q & ~w_q_next;
      r_conflict <= w_conflict;
      if (clr) begin
        r_cnt <= '0;
      end else if (w_conflict && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign q            = r_q;
  assign q_rise       = r_rise;
  assign q_fall       = r_fall;
  assign conflict     = r_conflict;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_flipflop_bank.sv
// Directed bench: one shared stimulus bus drives six WIDTH=4 variants
// (modes 0-3, a 2-bit counter, and a non-zero reset value).
module tb_sr_flipflop_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic [3:0] s;
  logic [3:0] r;

  logic [3:0] q_m      [4];
  logic [3:0] rise_m   [4];
  logic [3:0] fall_m   [4];
  logic       conf_m   [4];
  logic [7:0] cnt_m    [4];

  logic [3:0] q_sat, rise_sat, fall_sat;
  logic       conf_sat;
  logic [1:0] cnt_sat;

  logic [3:0] q_rv, rise_rv, fall_rv;
  logic       conf_rv;
  logic [7:0] cnt_rv;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    sr_flipflop_bank #(
      .WIDTH(4), .CONFLICT_MODE(g), .RESET_VALUE(4'b0000), .CNT_W(8)
    ) u_dut (
      .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r),
      .q(q_m[g]), .q_rise(rise_m[g]), .q_fall(fall_m[g]),
      .conflict(conf_m[g]), .conflict_cnt(cnt_m[g])
    );
  end

  sr_flipflop_bank #(
    .WIDTH(4), .CONFLICT_MODE(0), .RESET_VALUE(4'b0000), .CNT_W(2)
  ) u_sat (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r),
    .q(q_sat), .q_rise(rise_sat), .q_fall(fall_sat),
    .conflict(conf_sat), .conflict_cnt(cnt_sat)
  );

  sr_flipflop_bank #(
    .WIDTH(4), .CONFLICT_MODE(0), .RESET_VALUE(4'b0101), .CNT_W(8)
  ) u_rv (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r),
    .q(q_rv), .q_rise(rise_rv), .q_fall(fall_rv),
    .conflict(conf_rv), .conflict_cnt(cnt_rv)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i_en, input logic i_clr,
                       input logic [3:0] i_s, input logic [3:0] i_r);
    en  = i_en;
    clr = i_clr;
    s   = i_s;
    r   = i_r;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    #13;
    chk("rst_q",     32'(q_m[0]),    32'h0);
    chk("rst_rise",  32'(rise_m[0]), 32'h0);
    chk("rst_fall",  32'(fall_m[0]), 32'h0);
    chk("rst_conf",  32'(conf_m[0]), 32'h0);
    chk("rst_cnt",   32'(cnt_m[0]),  32'h0);
    chk("rst_rv_q",  32'(q_rv),      32'h5);

    @(negedge clk);
    reset = 1'b1;

    // Basic set then reset
    drive(1'b1, 1'b0, 4'b0011, 4'b0000); tick();
    chk("set_q",     32'(q_m[0]),    32'h3);
    chk("set_rise",  32'(rise_m[0]), 32'h3);
    chk("set_fall",  32'(fall_m[0]), 32'h0);
    chk("set_conf",  32'(conf_m[0]), 32'h0);
    chk("set_rv_q",  32'(q_rv),      32'h7);
    drive(1'b1, 1'b0, 4'b0000, 4'b0001); tick();
    chk("rst1_q",    32'(q_m[0]),    32'h2);
    chk("rst1_fall", 32'(fall_m[0]), 32'h1);
    chk("rst1_rise", 32'(rise_m[0]), 32'h0);

    // S=R=1 on channel 0 from q[0]=0, three edges
    drive(1'b1, 1'b0, 4'b0001, 4'b0001); tick();
    chk("m0_q",      32'(q_m[0]),    32'h2);
    chk("m1_q",      32'(q_m[1]),    32'h3);
    chk("m2_q",      32'(q_m[2]),    32'h2);
    chk("m3_q_e1",   32'(q_m[3]),    32'h3);
    chk("m3_rise_e1",32'(rise_m[3]), 32'h1);
    for (int m = 0; m < 4; m++) chk($sformatf("m%0d_conf", m), 32'(conf_m[m]), 32'h1);
    tick();
    chk("m3_q_e2",   32'(q_m[3]),    32'h2);
    chk("m3_fall_e2",32'(fall_m[3]), 32'h1);
    chk("m1_q_e2",   32'(q_m[1]),    32'h3);
    chk("m1_conf_e2",32'(conf_m[1]), 32'h1);
    chk("m1_rise_e2",32'(rise_m[1]), 32'h0);
    tick();
    chk("m3_q_e3",   32'(q_m[3]),    32'h3);
    chk("m3_rise_e3",32'(rise_m[3]), 32'h1);
    chk("m2_conf_e3",32'(conf_m[2]), 32'h1);
    chk("m0_cnt_e3", 32'(cnt_m[0]),  32'h3);
    chk("sat_cnt_e3",32'(cnt_sat),   32'h3);

    // Mixed set/reset per channel: q -> 1010, no conflict
    drive(1'b1, 1'b0, 4'b1000, 4'b0101); tick();
    chk("mix_q",     32'(q_m[0]),    32'ha);
    chk("mix_m3_q",  32'(q_m[3]),    32'ha);
    chk("mix_conf",  32'(conf_m[0]), 32'h0);
    chk("mix_cnt",   32'(cnt_m[0]),  32'h3);
    chk("mix_rise",  32'(rise_m[0]), 32'h8);

    // Disabled: requests and conflicts ignored
    drive(1'b0, 1'b0, 4'b1111, 4'b1111); tick();
    chk("en0_q",     32'(q_m[0]),    32'ha);
    chk("en0_rise",  32'(rise_m[0]), 32'h0);
    chk("en0_fall",  32'(fall_m[0]), 32'h0);
    chk("en0_conf",  32'(conf_m[0]), 32'h0);
    chk("en0_cnt",   32'(cnt_m[0]),  32'h3);

    // Clear beats enable and a simultaneous conflict
    drive(1'b1, 1'b1, 4'b0101, 4'b0101); tick();
    chk("clr_q",     32'(q_m[0]),    32'h0);
    chk("clr_fall",  32'(fall_m[0]), 32'ha);
    chk("clr_rise",  32'(rise_m[0]), 32'h0);
    chk("clr_conf",  32'(conf_m[0]), 32'h0);
    chk("clr_cnt",   32'(cnt_m[0]),  32'h0);
    chk("clr_rv_q",  32'(q_rv),      32'h5);
    chk("clr_rv_rise",32'(rise_rv),  32'h5);
    chk("clr_rv_fall",32'(fall_rv),  32'ha);

    // Saturation on the 2-bit counter
    drive(1'b1, 1'b0, 4'b1000, 4'b1000);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("sat_cnt_%0d", k), 32'(cnt_sat), (k < 3) ? 32'(k) : 32'd3);
      chk($sformatf("sat_conf_%0d", k), 32'(conf_sat), 32'h1);
    end
    chk("wide_cnt5", 32'(cnt_m[0]), 32'h5);

    drive(1'b1, 1'b0, 4'b1111, 4'b0000); tick();
    chk("pre_ar_q",   32'(q_m[0]),    32'hf);
    chk("pre_ar_cnt", 32'(cnt_m[0]),  32'h5);
    chk("pre_ar_rise",32'(rise_m[0]), 32'hf);

    // Async reset between edges
    #2 reset = 1'b0;
    #1;
    chk("ar_q",      32'(q_m[0]),    32'h0);
    chk("ar_cnt",    32'(cnt_m[0]),  32'h0);
    chk("ar_rise",   32'(rise_m[0]), 32'h0);
    chk("ar_fall",   32'(fall_m[0]), 32'h0);
    chk("ar_conf",   32'(conf_m[0]), 32'h0);
    chk("ar_sat_cnt",32'(cnt_sat),   32'h0);
    chk("ar_rv_q",   32'(q_rv),      32'h5);
    @(negedge clk);
    reset = 1'b1;

    drive(1'b1, 1'b0, 4'b1000, 4'b1000); tick();
    chk("post_ar_cnt",  32'(cnt_sat),  32'h1);
    chk("post_ar_conf", 32'(conf_sat), 32'h1);
    tick();
    chk("post_ar_cnt2", 32'(cnt_sat),  32'h2);
    drive(1'b1, 1'b1, 4'b1000, 4'b1000); tick();
    chk("clr_sat_cnt",  32'(cnt_sat),  32'h0);
    chk("clr_sat_conf", 32'(conf_sat), 32'h0);

    // Non-zero reset value restored by clear from 0000
    drive(1'b1, 1'b0, 4'b0000, 4'b1111); tick();
    chk("rv_zero_q",    32'(q_rv),     32'h0);
    chk("rv_zero_fall", 32'(fall_rv),  32'h5);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000); tick();
    chk("rv_clr_q",     32'(q_rv),     32'h5);
    chk("rv_clr_rise",  32'(rise_rv),  32'h5);
    chk("rv_clr_fall",  32'(fall_rv),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
